// File: rtl/piso_tx_if.sv
// piso_tx_if: handshake and serial-output bundle for piso_tx.
//   din_valid/din   : parallel word offered by the producer
//   din_ready       : serializer can take a word this cycle
//   q/q_valid/last  : registered serial bit, its qualifier, final-bit flag
//   busy            : a word is being shifted out
// Modports: slave = serializer side, master = producer/consumer side.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             din_ready;
  logic             q;
  logic             q_valid;
  logic             last;
  logic             busy;

  modport slave (
    input  din_valid,
    input  din,
    output din_ready,
    output q,
    output q_valid,
    output last,
    output busy
  );

  modport master (
    output din_valid,
    output din,
    input  din_ready,
    input  q,
    input  q_valid,
    input  last,
    input  busy
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter with valid/ready intake.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : piso_tx_if slave modport (din_valid, din, din_ready, q,
//           q_valid, last, busy)
// A word accepted on a handshake edge appears on q over the next WIDTH
// cycles, MSB or LSB first. A new word may be taken while the final bit is
// on q, giving gap-free back-to-back streaming.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  piso_tx_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;

  logic is_last;
  logic ready;
  logic accept;

  // Next-state logic: load on handshake, otherwise shift or fall back to IDLE.
  always_comb begin
    // last/ready depend only on registered state and counter
    is_last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    ready     = (state_q == IDLE) || is_last;
    accept    = bus.din_valid && ready;

    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;

    if (accept) begin
      // First bit goes straight to q; sreg keeps the remaining bits,
      // aligned so the next bit always sits at the output end.
      state_d   = SHIFT;
      cnt_d     = '0;
      q_valid_d = 1'b1;
      if (MSB_FIRST) begin
        q_d    = bus.din[WIDTH-1];
        sreg_d = {bus.din[WIDTH-2:0], 1'b0};
      end else begin
        q_d    = bus.din[0];
        sreg_d = {1'b0, bus.din[WIDTH-1:1]};
      end
    end else if (state_q == SHIFT) begin
      if (is_last) begin
        state_d   = IDLE;
        cnt_d     = '0;
        sreg_d    = '0;
        q_d       = 1'b0;
        q_valid_d = 1'b0;
      end else begin
        cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        q_valid_d = 1'b1;
        if (MSB_FIRST) begin
          q_d    = sreg_q[WIDTH-1];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
          q_d    = sreg_q[0];
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
      end
    end else begin
      state_d   = IDLE;
      cnt_d     = '0;
      sreg_d    = '0;
      q_d       = 1'b0;
      q_valid_d = 1'b0;
    end
  end

  // State, counter, shift register and registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      q_q       <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.din_ready = ready;
  assign bus.q         = q_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.last      = is_last;
  assign bus.busy      = (state_q == SHIFT);

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: parallel word width in bits, legal range 2..32.
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = din[WIDTH-1] shifted out first; 0 = din[0] shifted out first.
REQ-003 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port din_valid  input  1  parallel word on din is offered.
REQ-006 SHALL provide port din  input  WIDTH  parallel word to serialize.
REQ-007 SHALL provide port din_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL provide port q  output  1  registered serial data bit.
REQ-009 SHALL provide port q_valid  output  1  q carries a valid bit this cycle.
REQ-010 SHALL provide port last  output  1  q carries the final bit of the current word.
REQ-011 SHALL provide port busy  output  1  a word is being shifted out (state SHIFT).

Function
REQ-012 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 SHALL accept a word on any rising edge where din_valid = 1 and din_ready = 1 (handshake).
REQ-014 SHALL drive din_ready = 1 in IDLE, and in SHIFT only while last = 1; otherwise 0.
REQ-015 SHALL derive din_ready combinationally from state and bit counter only, never from din_valid.
REQ-016 On a handshake edge, SHALL capture din into an internal shift register, drive the first bit on q, set q_valid = 1, load the bit counter to 0, and enter SHIFT.
REQ-017 SHALL present the word's bits on q on WIDTH consecutive cycles, starting the cycle after the handshake edge (latency 1 cycle).
REQ-018 SHALL keep the bit counter width at clog2(WIDTH), advancing it by 1 per cycle in SHIFT.
REQ-019 SHALL assert last = 1 exactly when the counter equals WIDTH-1 in SHIFT.
REQ-020 When last = 1 with no handshake, SHALL return to IDLE on the next edge, with q_valid = 0 and q = 0.
REQ-021 When last = 1 and a handshake occurs, SHALL remain in SHIFT and present the new word's first bit on the next cycle, with no gap in q_valid.
REQ-022 SHALL ignore din and din_valid while din_ready = 0; changes to din after capture SHALL NOT affect q.
REQ-023 SHALL hold q = 0, q_valid = 0, last = 0, busy = 0 in IDLE.
REQ-024 SHALL set busy = 1 exactly while in SHIFT.

Reset
REQ-025 While reset = 1, SHALL immediately force state IDLE, counter 0, shift register 0, q = 0, q_valid = 0, last = 0, busy = 0; din_ready = 1.
REQ-026 Reset asserted mid-word SHALL discard the partial word; the first handshake after reset deassertion starts a fresh word.
REQ-027 A din_valid pulse coincident with reset = 1 SHALL NOT be accepted.

Verification
REQ-028 Single word, WIDTH=4, MSB_FIRST=1: din=4'b1011 with one-cycle din_valid -> q = 1,0,1,1 on the next 4 cycles; q_valid = 1 for exactly those 4; last = 1 only on the 4th; then IDLE.
REQ-029 LSB-first, MSB_FIRST=0: din=4'b1011 -> q = 1,1,0,1; last on the 4th bit.
REQ-030 Back-to-back: din_valid held high with 4'hA, then 4'h5 offered while last = 1 -> q = 1,0,1,0,0,1,0,1; q_valid continuously 1 for 8 cycles; din_ready = 1 only on cycles 0, 4, 8.
REQ-031 Busy rejection: din_valid = 1 with din=4'hF during bits 1-3 of word 4'h0 -> din_ready = 0, q stays 0,0,0,0; the 4'hF word is accepted only at last.
REQ-032 Reset mid-transfer: assert reset after 2 bits of 4'b1100 -> q, q_valid, busy drop to 0 immediately (before the next edge); next word 4'b0110 after release -> q = 0,1,1,0.
REQ-033 Data stability: change din every cycle during a shift of 4'b1001 -> q = 1,0,0,1 unaffected.
